// File: rtl/systolic_writeback_pkg.sv
// Shared types for the systolic result path: writeback FSM states and the
// signed saturation bounds for the default 16-bit memory word.
package SystolicTypes;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } wb_state_t;

    localparam int WB_ADDR_W  = 12;
    localparam int WB_N_W     = 4;
    localparam int SAT_MAX_16 = 32767;
    localparam int SAT_MIN_16 = -32768;

endpackage

// File: rtl/systolic_writeback_sat_clip.sv
// Combinational signed clip from an ACC_WIDTH accumulator down to a WIDTH word,
// flagging whenever the value had to be clamped.
module sat_clip #(
    parameter int ACC_WIDTH = 32,
    parameter int WIDTH     = 16
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    output logic signed [WIDTH-1:0]     o_sat,
    output logic                        o_clip
);

    localparam logic signed [ACC_WIDTH-1:0] HI =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] LO =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    always_comb begin
        o_sat  = i_acc[WIDTH-1:0];
        o_clip = 1'b0;
        if (i_acc > HI) begin
            o_sat  = HI[WIDTH-1:0];
            o_clip = 1'b1;
        end else if (i_acc < LO) begin
            o_sat  = LO[WIDTH-1:0];
            o_clip = 1'b1;
        end
    end

endmodule

// File: rtl/systolic_writeback.sv
// Captures n result columns from the systolic array into an NxN buffer, then
// drains them row-major to memory with a valid/ready write handshake.
module systolic_writeback
    import SystolicTypes::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WB_ADDR_W-1:0]            addr_C,
    input  logic [WB_N_W-1:0]               n,
    input  logic                            col_valid,
    input  logic [N-1:0][ACC_WIDTH-1:0]     col_data,
    input  logic                            mem_ready,
    output logic                            mem_write,
    output logic [WB_ADDR_W-1:0]            mem_addr,
    output logic [WIDTH-1:0]                mem_data,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);

    localparam int IW = $clog2(N);

    wb_state_t              r_state;
    logic [IW-1:0]          r_row;
    logic [IW-1:0]          r_col;
    logic [IW-1:0]          r_last;
    logic [WB_ADDR_W-1:0]   r_base;
    logic [WB_ADDR_W-1:0]   r_mem_addr;
    logic [WIDTH-1:0]       r_mem_data;
    logic                   r_mem_write;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;
    logic [WIDTH-1:0]       r_buf [N][N];

    logic [WIDTH-1:0]       w_sat [N];
    logic [N-1:0]           w_clip;
    logic [N-1:0]           w_row_en;
    logic [IW-1:0]          w_last_in;
    logic [IW-1:0]          w_next_row;
    logic [IW-1:0]          w_next_col;
    logic                   w_cap;
    logic                   w_ovf_hit;
    logic                   w_last_elem;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            sat_clip #(
                .ACC_WIDTH (ACC_WIDTH),
                .WIDTH     (WIDTH)
            ) u_sat (
                .i_acc  (col_data[gi]),
                .o_sat  (w_sat[gi]),
                .o_clip (w_clip[gi])
            );
            assign w_row_en[gi] = (IW'(gi) <= r_last);
        end
    endgenerate

    // n of 0 or beyond the array size means a full N x N job.
    always_comb begin
        w_last_in = IW'(N - 1);
        if (n != '0 && n <= WB_N_W'(N)) begin
            w_last_in = IW'(n - 4'd1);
        end
    end

    assign w_cap       = (r_state == CAPTURE) && col_valid;
    assign w_ovf_hit   = |(w_clip & w_row_en);
    assign w_last_elem = (r_row == r_last) && (r_col == r_last);
    assign w_next_col  = (r_col == r_last) ? '0 : r_col + 1'b1;
    assign w_next_row  = (r_col == r_last) ? r_row + 1'b1 : r_row;

    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int r = 0; r < N; r++) begin
                if (w_row_en[r]) begin
                    r_buf[r][r_col] <= w_sat[r];
                end
            end
        end
    end

    // Row-major order over a contiguous block, so the address simply counts up
    // and wraps at the 12-bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_last      <= '0;
            r_base      <= '0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_write <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base  <= addr_C;
                        r_last  <= w_last_in;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (col_valid) begin
                        if (w_ovf_hit) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_col == r_last) begin
                            r_state     <= DRAIN;
                            r_row       <= '0;
                            r_col       <= '0;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= r_base;
                            // A 1x1 job drains the word being captured on this edge.
                            r_mem_data  <= (r_last == '0) ? w_sat[0] : r_buf[0][0];
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        if (w_last_elem) begin
                            r_state     <= DONE;
                            r_mem_write <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_row      <= w_next_row;
                            r_col      <= w_next_col;
                            r_mem_addr <= r_mem_addr + 12'd1;
                            r_mem_data <= r_buf[w_next_row][w_next_col];
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed bench for systolic_writeback: basic, saturation, backpressure,
// address wrap, ignored inputs and reset abort scenarios.
module tb_systolic_writeback;

    localparam int N         = 4;
    localparam int WIDTH     = 16;
    localparam int ACC_WIDTH = 32;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        start = 1'b0;
    logic [11:0]                 addr_C = '0;
    logic [3:0]                  n = '0;
    logic                        col_valid = 1'b0;
    logic [N-1:0][ACC_WIDTH-1:0] col_data = '0;
    logic                        mem_ready = 1'b0;
    logic                        mem_write;
    logic [11:0]                 mem_addr;
    logic [WIDTH-1:0]            mem_data;
    logic                        busy;
    logic                        done;
    logic                        overflow;

    systolic_writeback #(
        .N         (N),
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addr_C    (addr_C),
        .n         (n),
        .col_valid (col_valid),
        .col_data  (col_data),
        .mem_ready (mem_ready),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   wr_addr[$];
    int   wr_data[$];
    int   drain_cycles;
    int   done_cycle;
    int   stall_bad;
    int   wr_when_done;
    bit   timed_out;
    logic busy_at_capture;
    logic ovf_at_capture;

    // Starts a job and streams ncols columns; col_data[r] = 10*r + c unless sat.
    task automatic send_job(input logic [11:0] a, input logic [3:0] nv, input int ncols, input bit sat);
        @(negedge clk);
        start  = 1'b1;
        addr_C = a;
        n      = nv;
        @(negedge clk);
        start = 1'b0;
        busy_at_capture = busy;
        ovf_at_capture  = overflow;
        for (int c = 0; c < ncols; c++) begin
            col_valid = 1'b1;
            for (int r = 0; r < N; r++) begin
                int v;
                v = 10 * r + c;
                if (sat && r == 1) v = 40000;
                if (sat && r == 2) v = -40000;
                col_data[r] = ACC_WIDTH'(v);
            end
            if (c < ncols - 1) @(negedge clk);
        end
    endtask

    // mode 0: ready high; 1: ready toggles 1/0; 2: start/col_valid pulse in DRAIN;
    // 3: stop after the 5th accepted write is presented.
    task automatic collect(input int mode, input int max_cycles);
        bit          prev_stall;
        logic [11:0] pa;
        logic [15:0] pd;
        logic        rdy;
        int          accepts;
        wr_addr.delete();
        wr_data.delete();
        drain_cycles = 0;
        done_cycle   = 0;
        stall_bad    = 0;
        wr_when_done = 0;
        timed_out    = 1'b0;
        accepts      = 0;
        prev_stall   = 1'b0;
        pa = '0;
        pd = '0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clk);
            col_valid = 1'b0;
            start     = 1'b0;
            if (done) begin
                done_cycle = i;
                if (mem_write) wr_when_done++;
                break;
            end
            if (mem_write) begin
                drain_cycles++;
                if (prev_stall && (mem_addr !== pa || mem_data !== pd)) stall_bad++;
            end
            rdy = (mode == 1) ? (drain_cycles % 2 == 1) : 1'b1;
            mem_ready = rdy;
            if (mem_write && rdy) begin
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(int'($signed(mem_data)));
                accepts++;
                $display("write #%0d addr=%0d data=%0d", accepts, mem_addr, $signed(mem_data));
            end
            prev_stall = mem_write && !rdy;
            pa = mem_addr;
            pd = mem_data;
            if (mode == 2 && i == 3) begin
                start     = 1'b1;
                addr_C    = 12'd100;
                n         = 4'd2;
                col_valid = 1'b1;
                col_data  = {N{32'd7}};
            end
            if (mode == 3 && accepts == 5) break;
        end
        if (done_cycle == 0 && mode != 3) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
        checks++; if (mem_addr !== 12'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_data !== 16'd0) begin errors++; $display("FAIL reset_mem_data: got %0d expected 0", mem_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_job(12'd32, 4'd4, 4, 1'b0);
        checks++; if (busy_at_capture !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_at_capture); end
        collect(0, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL basic_count: got %0d expected 16", wr_addr.size()); end
        for (int k = 0; k < 16 && k < wr_addr.size(); k++) begin
            checks++; if (wr_addr[k] !== 32 + k) begin errors++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", k, wr_addr[k], 32 + k); end
            checks++; if (wr_data[k] !== 10 * (k / 4) + (k % 4)) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", k, wr_data[k], 10 * (k / 4) + (k % 4)); end
        end
        checks++; if (drain_cycles != 16) begin errors++; $display("FAIL basic_drain_cycles: got %0d expected 16", drain_cycles); end
        checks++; if (done_cycle != 17) begin errors++; $display("FAIL basic_latency: got %0d expected 17", done_cycle); end
        checks++; if (wr_when_done != 0) begin errors++; $display("FAIL basic_write_in_done: got %0d expected 0", wr_when_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_saturation();
        int exp_d;
        send_job(12'd32, 4'd4, 4, 1'b1);
        collect(0, 200);
        checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL sat_count: got %0d expected 16", wr_addr.size()); end
        for (int k = 0; k < 16 && k < wr_addr.size(); k++) begin
            exp_d = 10 * (k / 4) + (k % 4);
            if (k / 4 == 1) exp_d = 32767;
            if (k / 4 == 2) exp_d = -32768;
            checks++; if (wr_data[k] !== exp_d) begin errors++; $display("FAIL sat_data[%0d]: got %0d expected %0d", k, wr_data[k], exp_d); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow_done: got %b expected 1", overflow); end
        repeat (3) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_backpressure();
        send_job(12'd32, 4'd4, 4, 1'b0);
        checks++; if (ovf_at_capture !== 1'b0) begin errors++; $display("FAIL bp_overflow_cleared: got %b expected 0", ovf_at_capture); end
        collect(1, 300);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
        checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL bp_count: got %0d expected 16", wr_addr.size()); end
        for (int k = 0; k < 16 && k < wr_addr.size(); k++) begin
            checks++; if (wr_addr[k] !== 32 + k) begin errors++; $display("FAIL bp_addr[%0d]: got %0d expected %0d", k, wr_addr[k], 32 + k); end
            checks++; if (wr_data[k] !== 10 * (k / 4) + (k % 4)) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", k, wr_data[k], 10 * (k / 4) + (k % 4)); end
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_bad); end
        checks++; if (drain_cycles != 31) begin errors++; $display("FAIL bp_drain_cycles: got %0d expected 31", drain_cycles); end
        checks++; if (done_cycle != 32) begin errors++; $display("FAIL bp_latency: got %0d expected 32", done_cycle); end
        mem_ready = 1'b1;
    endtask

    task automatic test_wrap();
        int exp_a[4] = '{4094, 4095, 0, 1};
        int exp_d[4] = '{0, 1, 10, 11};
        send_job(12'd4094, 4'd2, 2, 1'b0);
        collect(0, 50);
        checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", wr_addr.size()); end
        for (int k = 0; k < 4 && k < wr_addr.size(); k++) begin
            checks++; if (wr_addr[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, wr_addr[k], exp_a[k]); end
            checks++; if (wr_data[k] !== exp_d[k]) begin errors++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", k, wr_data[k], exp_d[k]); end
        end
        checks++; if (done_cycle != 5) begin errors++; $display("FAIL wrap_latency: got %0d expected 5", done_cycle); end
    endtask

    task automatic test_ignored();
        send_job(12'd32, 4'd4, 4, 1'b0);
        collect(2, 200);
        checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL ign_count: got %0d expected 16", wr_addr.size()); end
        for (int k = 0; k < 16 && k < wr_addr.size(); k++) begin
            checks++; if (wr_addr[k] !== 32 + k) begin errors++; $display("FAIL ign_addr[%0d]: got %0d expected %0d", k, wr_addr[k], 32 + k); end
            checks++; if (wr_data[k] !== 10 * (k / 4) + (k % 4)) begin errors++; $display("FAIL ign_data[%0d]: got %0d expected %0d", k, wr_data[k], 10 * (k / 4) + (k % 4)); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart: got busy %b expected 0", busy); end
    endtask

    task automatic test_abort();
        send_job(12'd32, 4'd4, 4, 1'b0);
        collect(3, 200);
        checks++; if (wr_addr.size() != 5) begin errors++; $display("FAIL abort_pre_count: got %0d expected 5", wr_addr.size()); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL abort_mem_write: got %b expected 0", mem_write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (mem_addr !== 12'd0) begin errors++; $display("FAIL abort_mem_addr: got %0d expected 0", mem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL abort_hold_write: got %b expected 0", mem_write); end
        rst = 1'b1;
        send_job(12'd200, 4'd0, 4, 1'b0);
        checks++; if (busy_at_capture !== 1'b1) begin errors++; $display("FAIL abort_restart_busy: got %b expected 1", busy_at_capture); end
        collect(0, 200);
        checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL abort_clean_count: got %0d expected 16", wr_addr.size()); end
        for (int k = 0; k < 16 && k < wr_addr.size(); k++) begin
            checks++; if (wr_addr[k] !== 200 + k) begin errors++; $display("FAIL abort_clean_addr[%0d]: got %0d expected %0d", k, wr_addr[k], 200 + k); end
            checks++; if (wr_data[k] !== 10 * (k / 4) + (k % 4)) begin errors++; $display("FAIL abort_clean_data[%0d]: got %0d expected %0d", k, wr_data[k], 10 * (k / 4) + (k % 4)); end
        end
        checks++; if (done_cycle != 17) begin errors++; $display("FAIL abort_clean_latency: got %0d expected 17", done_cycle); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_clean_overflow: got %b expected 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_wrap();
        test_ignored();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_writeback.md
SYSTOLIC_WRITEBACK -- requirements
Module: systolic_writeback

Interface
REQ-001 Parameter N, default 4: array dimension; maximum columns and rows buffered.
REQ-002 Parameter WIDTH, default 16: memory word width, signed.
REQ-003 Parameter ACC_WIDTH, default 32: width of incoming signed accumulator results.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a capture/drain job.
REQ-007 addr_C  in  12  unsigned base address of result matrix C.
REQ-008 n  in  4  unsigned active matrix size.
REQ-009 col_valid  in  1  col_data holds one result column this cycle.
REQ-010 col_data  in  N x ACC_WIDTH  signed results; index r is row r of the current column.
REQ-011 mem_ready  in  1  memory accepted the write presented this cycle.
REQ-012 mem_write  out  1  write request.
REQ-013 mem_addr  out  12  write address.
REQ-014 mem_data  out  WIDTH  signed write data.
REQ-015 busy  out  1  high in CAPTURE or DRAIN.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 overflow  out  1  sticky saturation flag.

Function
REQ-018 The block SHALL implement states IDLE, CAPTURE, DRAIN and DONE.
REQ-019 In IDLE, start SHALL latch addr_C and n, clear the column index, row index and overflow, and enter CAPTURE next cycle.
REQ-020 Latched n SHALL be clamped: n=0 or n>N is treated as N.
REQ-021 start SHALL be ignored in CAPTURE, DRAIN and DONE.
REQ-022 In CAPTURE, each col_valid SHALL store col_data[0..n-1] into buffer column col_idx and then increment col_idx.
REQ-023 Capture of column n-1 SHALL move the block to DRAIN on the next edge.
REQ-024 col_valid outside CAPTURE SHALL be ignored.
REQ-025 Values stored in the buffer SHALL be saturated to the signed WIDTH range: above 32767 -> 32767; below -32768 -> -32768 (WIDTH=16).
REQ-026 Any saturation event SHALL set overflow; overflow SHALL stay high until the next accepted start.
REQ-027 In DRAIN, mem_write SHALL be 1, with mem_addr = addr_C + r*n + c (row-major, modulo 4096) and mem_data = buf[r][c].
REQ-028 Drain order SHALL be c fastest, then r.
REQ-029 The element SHALL advance only on a cycle where mem_write and mem_ready are both high.
REQ-030 mem_addr and mem_data SHALL hold stable while mem_ready is low.
REQ-031 Acceptance of element (n-1, n-1) SHALL move the block to DONE; mem_write SHALL be 0 from that next cycle.
REQ-032 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-033 Minimum job latency, from the last column capture to done, SHALL be n*n + 1 cycles when mem_ready is held high.
REQ-034 mem_write SHALL be 0 in all states other than DRAIN.

Reset
REQ-035 While rst=0, the state SHALL be IDLE and mem_write, done, busy and overflow SHALL be 0.
REQ-036 While rst=0, mem_addr and mem_data SHALL be 0, and all indices SHALL be 0.
REQ-037 Reset mid-job SHALL abort the job immediately, with no further writes; buffer contents need not be cleared.

Structure
REQ-038 State enum wb_state_t SHALL be added to the shared SystolicTypes package, alongside the saturation bound constants.
REQ-039 Saturation SHALL be a separate combinational sub-module, sat_clip (ACC_WIDTH -> WIDTH, overflow flag), instantiated once per row.

Verification
REQ-040 The bench SHALL cover a basic job: n=4, addr_C=32, columns c with col_data[r]=10*r+c, mem_ready=1 -> 16 writes at addresses 32..47 with data 0,1,2,3,10,...,33; done pulses once; overflow=0.
REQ-041 The bench SHALL cover saturation: col_data[1]=40000 and col_data[2]=-40000 -> written values 32767 and -32768; overflow=1 until the next start.
REQ-042 The bench SHALL cover backpressure: mem_ready toggling 1/0 every cycle -> same 16 writes in the same order; address and data stable during stalls; 31 DRAIN cycles.
REQ-043 The bench SHALL cover a small and wrapping job: n=2 with addr_C=4094 -> writes at 4094, 4095, 0, 1; done after the 4th acceptance.
REQ-044 The bench SHALL cover ignored inputs: start and col_valid pulsed during DRAIN -> no effect on the write sequence or the latched addr_C.
REQ-045 The bench SHALL cover reset abort: rst=0 after the 5th accepted write -> mem_write=0 asynchronously; the next start runs a full clean job.
